// File: rtl/key_debouncer_pkg.sv
// Shared types and elaboration helpers for the key debouncer.
// Holds the per-channel FSM state encoding and the counter-width calculation.
package key_debouncer_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } key_state_t;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // A counter only ever holds 0..max_count-1; keep at least one bit.
    function automatic int counter_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchronizer, debounce/autorepeat FSM, registered strobes.
// The raw key is active-low; every output is active-high and registered.
module key_debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W = counter_width(max_of3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                                 REPEAT_RATE_CYCLES));
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);

    logic [1:0]       sync_reg;
    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
    logic [CNT_W-1:0] rp_cnt_reg, rp_cnt_next;
    logic             pressed_next, press_next, release_next, repeat_next;
    logic             key_low;

    // Synchronizer resets to "released" so a held key is re-debounced after reset.
    assign key_low = ~sync_reg[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg      <= 2'b11;
            state_reg     <= IDLE;
            db_cnt_reg    <= '0;
            rp_cnt_reg    <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], key};
            state_reg     <= state_next;
            db_cnt_reg    <= db_cnt_next;
            rp_cnt_reg    <= rp_cnt_next;
            pressed       <= pressed_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            repeat_pulse  <= repeat_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        db_cnt_next  = db_cnt_reg;
        rp_cnt_next  = rp_cnt_reg;
        pressed_next = pressed;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (key_low) begin
                    state_next  = PRESS_WAIT;
                    db_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_low) begin
                    state_next = IDLE;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next   = HELD;
                    rp_cnt_next  = '0;
                    press_next   = 1'b1;
                    pressed_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + 1'b1;
                end
            end
            HELD, REPEAT: begin
                // Same counter serves the initial delay (HELD) and the repeat period.
                if (!key_low) begin
                    state_next  = RELEASE_WAIT;
                    db_cnt_next = '0;
                end else if (rp_cnt_reg == ((state_reg == HELD) ? DELAY_LAST : RATE_LAST)) begin
                    state_next  = REPEAT;
                    rp_cnt_next = '0;
                    repeat_next = 1'b1;
                end else begin
                    rp_cnt_next = rp_cnt_reg + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (key_low) begin
                    state_next  = HELD;
                    rp_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    pressed_next = 1'b0;
                end else begin
                    db_cnt_next = db_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer with autorepeat: NUM_KEYS fully independent channels.
// Keys are raw active-low push-buttons; outputs are registered active-high levels/strobes.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS            = 2,
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    if (NUM_KEYS < 1) begin : g_bad_num_keys
        $fatal(1, "key_debouncer: NUM_KEYS must be >= 1");
    end
    if (max_of3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) < 1 ||
        DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cycles
        $fatal(1, "key_debouncer: all cycle parameters must be >= 1");
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .key           (key[gi]),
            .pressed       (pressed[gi]),
            .press_pulse   (press_pulse[gi]),
            .release_pulse (release_pulse[gi]),
            .repeat_pulse  (repeat_pulse[gi])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: run-length reference model feeding a per-cycle scoreboard,
// plus directed timing checks on the logged pulse cycles.
module tb_key_debouncer;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key;
    logic [NK-1:0] pressed, press_pulse, release_pulse, repeat_pulse;

    key_debouncer #(
        .NUM_KEYS            (NK),
        .DEBOUNCE_CYCLES     (DB),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_RATE_CYCLES  (RR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key           (key),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    typedef struct packed {
        int            cyc;
        logic [NK-1:0] pressed;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] rep;
    } exp_t;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    exp_t exp_q[$];
    ev_t  ev_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: raw-sample delay line plus run lengths and hold start time.
    logic m_p0[NK], m_p1[NK], m_pressed[NK];
    int   low_run[NK], high_run[NK], held_start[NK];

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_edge(input logic [NK-1:0] raw, input logic rst);
        exp_t e;
        logic s;
        int   age;
        e = '0;
        cyc++;
        e.cyc = cyc;
        for (int c = 0; c < NK; c++) begin
            if (rst) begin
                m_p0[c] = 1'b1; m_p1[c] = 1'b1; m_pressed[c] = 1'b0;
                low_run[c] = 0; high_run[c] = 0; held_start[c] = 0;
            end else begin
                s = m_p1[c];
                m_p1[c] = m_p0[c];
                m_p0[c] = raw[c];
                if (!m_pressed[c]) begin
                    if (!s) begin
                        low_run[c]++;
                        if (low_run[c] == DB + 1) begin
                            e.press[c] = 1'b1; m_pressed[c] = 1'b1;
                            held_start[c] = cyc; high_run[c] = 0;
                        end
                    end else begin
                        low_run[c] = 0;
                    end
                end else if (s) begin
                    high_run[c]++;
                    if (high_run[c] == DB + 1) begin
                        e.rel[c] = 1'b1; m_pressed[c] = 1'b0; low_run[c] = 0;
                    end
                end else if (high_run[c] > 0) begin
                    high_run[c] = 0;
                    held_start[c] = cyc;
                end else begin
                    age = cyc - held_start[c];
                    if (age >= RD && (age - RD) % RR == 0) e.rep[c] = 1'b1;
                end
            end
            e.pressed[c] = m_pressed[c];
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [NK-1:0] k, input logic rst);
        @(negedge clk);
        key   = k;
        reset = rst;
        model_edge(k, rst);
    endtask

    task automatic run(input logic [NK-1:0] k, input logic rst, input int n);
        for (int i = 0; i < n; i++) step(k, rst);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int count_ev(input int kind, input int ch, input int lo, input int hi);
        int n;
        n = 0;
        foreach (ev_log[i])
            if (ev_log[i].kind == kind && ev_log[i].ch == ch &&
                ev_log[i].cyc >= lo && ev_log[i].cyc <= hi) n++;
        return n;
    endfunction

    // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
    initial begin
        exp_t                e;
        logic [4*NK-1:0]     act;
        logic [4*NK-1:0]     req;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pressed, press_pulse, release_pulse, repeat_pulse};
                req = {e.pressed, e.press, e.rel, e.rep};
                checks++;
                if (act !== req) begin
                    errors++;
                    $display("FAIL scoreboard cyc=%0d actual=%b required=%b (pressed,press,release,repeat)",
                             e.cyc, act, req);
                end
                for (int c = 0; c < NK; c++) begin
                    if (press_pulse[c] === 1'b1)   ev_log.push_back('{e.cyc, c, K_PRESS});
                    if (release_pulse[c] === 1'b1) ev_log.push_back('{e.cyc, c, K_REL});
                    if (repeat_pulse[c] === 1'b1)  ev_log.push_back('{e.cyc, c, K_REP});
                end
            end
        end
    end

    initial begin
        int            n1, m1, g1, p2, b0, r1, s1;
        logic [NK-1:0] cur;
        int            rem[NK];
        reset = 1'b1;
        key   = '1;
        #1;
        chk("reset_state", int'({pressed, press_pulse, release_pulse, repeat_pulse}), 0);
        run(2'b11, 1'b1, 3);
        run(2'b11, 1'b0, 10);

        n1 = cyc + 1; run(2'b10, 1'b0, 70);
        m1 = cyc + 1; run(2'b11, 1'b0, 12);
        g1 = cyc + 1; run(2'b10, 1'b0, 3); run(2'b11, 1'b0, 12);
        p2 = cyc + 1; run(2'b10, 1'b0, 30);
        b0 = cyc + 1; run(2'b11, 1'b0, 2); run(2'b10, 1'b0, 40); run(2'b11, 1'b0, 12);
        run(2'b10, 1'b0, 15);

        // Assert reset mid-cycle while key 0 is held and pressed.
        @(negedge clk);
        chk("pressed_before_reset", int'(pressed[0]), 1);
        key = 2'b10;
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async_clear", int'({pressed, press_pulse, release_pulse, repeat_pulse}), 0);
        model_edge(key, 1'b1);
        run(2'b10, 1'b1, 3);
        r1 = cyc + 1; run(2'b10, 1'b0, 20); run(2'b11, 1'b0, 12);
        s1 = cyc + 1; run(2'b00, 1'b0, 10); run(2'b11, 1'b0, 12);

        cur = '1;
        for (int c = 0; c < NK; c++) rem[c] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NK; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = 1'($urandom_range(0, 1));
                    rem[c] = $urandom_range(1, 35);
                end
                rem[c]--;
            end
            if ($urandom_range(0, 299) == 0) run(cur, 1'b1, 2);
            else step(cur, 1'b0);
        end
        run(2'b11, 1'b0, 20);
        @(posedge clk);
        #2;

        chk("press0_latency",     count_ev(K_PRESS, 0, n1 + 6, n1 + 6), 1);
        chk("press0_not_early",   count_ev(K_PRESS, 0, n1, n1 + 5), 0);
        chk("ch1_quiet",          count_ev(K_PRESS, 1, n1, m1 + 12) + count_ev(K_REL, 1, n1, m1 + 12)
                                  + count_ev(K_REP, 1, n1, m1 + 12), 0);
        chk("no_repeat_before_delay", count_ev(K_REP, 0, n1 + 7, n1 + 25), 0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("repeat_%0d", k), count_ev(K_REP, 0, n1 + 26 + 8 * k, n1 + 26 + 8 * k), 1);
        chk("release0_latency",   count_ev(K_REL, 0, m1 + 6, m1 + 6), 1);
        chk("release0_not_early", count_ev(K_REL, 0, m1, m1 + 5), 0);
        chk("glitch_no_press",    count_ev(K_PRESS, 0, g1, g1 + 14), 0);
        chk("bounce_press",       count_ev(K_PRESS, 0, p2 + 6, p2 + 6), 1);
        chk("bounce_no_release",  count_ev(K_REL, 0, b0, b0 + 47), 0);
        chk("bounce_no_early_rep", count_ev(K_REP, 0, b0, b0 + 23), 0);
        chk("bounce_repeat_restart", count_ev(K_REP, 0, b0 + 24, b0 + 24), 1);
        chk("reset_no_release",   count_ev(K_REL, 0, r1 - 6, r1 + 5), 0);
        chk("reset_repress",      count_ev(K_PRESS, 0, r1 + 6, r1 + 6), 1);
        chk("reset_repress_not_early", count_ev(K_PRESS, 0, r1, r1 + 5), 0);
        chk("both_press0",        count_ev(K_PRESS, 0, s1 + 6, s1 + 6), 1);
        chk("both_press1",        count_ev(K_PRESS, 1, s1 + 6, s1 + 6), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 2: number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples needed to accept a level change.
REQ-003 SHALL have parameter REPEAT_DELAY_CYCLES, default 25000000: held cycles from press_pulse to first repeat_pulse.
REQ-004 SHALL have parameter REPEAT_RATE_CYCLES, default 5000000: cycles between subsequent repeat_pulses.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port key, input, NUM_KEYS: raw asynchronous push-buttons, active-low (0 = pressed).
REQ-008 SHALL have port pressed, output, NUM_KEYS: debounced level, active-high.
REQ-009 SHALL have port press_pulse, output, NUM_KEYS: one-cycle strobe on accepted press.
REQ-010 SHALL have port release_pulse, output, NUM_KEYS: one-cycle strobe on accepted release.
REQ-011 SHALL have port repeat_pulse, output, NUM_KEYS: one-cycle autorepeat strobe while held.

Function
REQ-012 Each key bit SHALL pass through a 2-flop synchronizer before any other logic; channels fully independent.
REQ-013 Per-channel FSM states SHALL be IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
REQ-014 IDLE: synchronized key low -> PRESS_WAIT, debounce counter cleared; otherwise stay.
REQ-015 PRESS_WAIT: key low increments counter; key high -> IDLE, no pulse; counter reaching DEBOUNCE_CYCLES-1 with key low -> HELD.
REQ-016 Entry to HELD from PRESS_WAIT SHALL assert press_pulse for exactly one cycle and set pressed=1 in that same cycle.
REQ-017 Latency: for raw key first sampled low at edge N and held low, press_pulse SHALL be high in cycle N+2+DEBOUNCE_CYCLES.
REQ-018 Glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no change of pressed.
REQ-019 HELD: repeat counter counts from 0; at REPEAT_DELAY_CYCLES-1 -> REPEAT with one-cycle repeat_pulse.
REQ-020 REPEAT: repeat_pulse every REPEAT_RATE_CYCLES cycles while key low; counter wraps to 0 at each pulse.
REQ-021 HELD/REPEAT with synchronized key high -> RELEASE_WAIT, debounce counter cleared, repeat counting stops.
REQ-022 RELEASE_WAIT: key low again before completion -> HELD, repeat counter cleared, no pulses; DEBOUNCE_CYCLES consecutive high -> IDLE with one-cycle release_pulse and pressed=0 in that cycle.
REQ-023 press_pulse, repeat_pulse and release_pulse SHALL be mutually exclusive per channel in any cycle.
REQ-024 Counters SHALL be sized $clog2 of the largest parameter, never overflow, saturation not required.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 reset asserted SHALL immediately force: synchronizer flops 1, FSM IDLE, counters 0, pressed/press_pulse/release_pulse/repeat_pulse 0.
REQ-027 Reset mid-press SHALL emit no release_pulse; after deassertion a still-held key SHALL be re-debounced and emit press_pulse per REQ-017.

Structure
REQ-028 Package key_debouncer_pkg SHALL hold the FSM state enum typedef.
REQ-029 One sub-module key_debounce_channel SHALL implement synchronizer, FSM and counters for one key; top instantiates NUM_KEYS via generate.
REQ-030 Parameters SHALL be checked at elaboration: all cycle parameters >= 1, NUM_KEYS >= 1.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8, NUM_KEYS=2)
REQ-031 key[0] low from edge 10, held -> press_pulse[0] only in cycle 16, pressed[0]=1 from 16, key[1] outputs stay 0.
REQ-032 key[0] low 3 cycles then high -> no pulses, pressed[0] stays 0.
REQ-033 key[0] held 60 cycles after press -> repeat_pulse[0] at press+20, +28, +36, +44, +52.
REQ-034 key[0] released -> release_pulse[0] 6 cycles after raw rise; 2-cycle high bounce during RELEASE_WAIT -> no release_pulse, repeat restarts after 20 held cycles.
REQ-035 reset asserted while pressed[0]=1 -> all outputs 0 same cycle; key still low after deassertion -> new press_pulse 6 cycles later.
REQ-036 both keys pressed same edge -> press_pulse[1:0]=2'b11 in the same cycle.
